qspi_read_scheduler: RTL

QSPI_READ_SCHEDULER -- requirements
Module: qspi_read_scheduler

---
 rtl/qspi_read_pkg.sv | 32 +++
 rtl/rr_arb2.sv | 39 +++
 rtl/qspi_read_scheduler.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/qspi_read_pkg.sv
// Shared definitions for the QSPI read scheduler: state encoding, flash
// geometry defaults and SPI lane-mode codes.
package qspi_read_pkg;

    // Bytes per flash die; the die index is the address bit just above it.
    localparam logic [31:0] DIE_SIZE = 32'h0200_0000;

    // Largest engine segment; segments never straddle a SEG_MAX-aligned page.
    localparam int unsigned SEG_MAX = 256;

    // SPI lane modes as presented on mode0/mode1 and eng_mode.
    localparam logic [1:0] MODE_SINGLE  = 2'b00;
    localparam logic [1:0] MODE_DUAL    = 2'b01;
    localparam logic [1:0] MODE_QUAD    = 2'b10;
    localparam logic [1:0] MODE_ILLEGAL = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARB      = 3'd1,
        ST_CHECK    = 3'd2,
        ST_DIE      = 3'd3,
        ST_DIE_WAIT = 3'd4,
        ST_ISSUE    = 3'd5,
        ST_WAIT     = 3'd6,
        ST_FIN      = 3'd7
    } state_t;

    function automatic logic mode_is_legal(input logic [1:0] mode);
        return mode != MODE_ILLEGAL;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The preference pointer moves only when a grant
// is actually taken (advance), so a requester that is refused keeps priority.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    // pref_q = 1 means requester 1 wins a tie; reset prefers requester 0.
    logic pref_q;
    logic pref_d;

    // Grant selection and pointer update; the winner yields priority next time.
    always_comb begin
        gnt    = 2'b00;
        pref_d = pref_q;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = pref_q ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
        if (advance && (gnt != 2'b00)) begin
            pref_d = gnt[0];
        end
    end

    // Preference pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pref_q <= 1'b0;
        end else begin
            pref_q <= pref_d;
        end
    end

endmodule

// File: rtl/qspi_read_scheduler.sv
// QSPI read scheduler: arbitrates two byte-range read requesters and breaks
// each range into page-bounded engine segments, switching flash die on the way.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | no owner; waits for any req
// ARB      | round-robin pick, latch owner's range and mode
// CHECK    | validate range/mode, decide whether a die switch is needed
// DIE      | issue die-switch command to the engine
// DIE_WAIT | wait for engine to finish the die switch
// ISSUE    | wait for FIFO room, then issue one segment
// WAIT     | wait for segment completion, advance cur_addr
// FIN      | done/err pulse visible, release grant
module qspi_read_scheduler #(
    parameter logic [31:0] DIE_SIZE = qspi_read_pkg::DIE_SIZE,
    parameter int unsigned SEG_MAX  = qspi_read_pkg::SEG_MAX
) (
    input  logic        CLK_25M_CKMNG_MAIN_PLD,
    input  logic        PWRGD_P1V2_MAX10_AUX_PLD_R,
    input  logic [1:0]  req,
    input  logic [31:0] start_addr0,
    input  logic [31:0] end_addr0,
    input  logic [31:0] start_addr1,
    input  logic [31:0] end_addr1,
    input  logic [1:0]  mode0,
    input  logic [1:0]  mode1,
    output logic [1:0]  gnt,
    output logic [1:0]  done,
    output logic [1:0]  err,
    output logic        busy,
    output logic        eng_start,
    output logic [31:0] eng_addr,
    output logic [8:0]  eng_len,
    output logic [1:0]  eng_mode,
    output logic        eng_die_switch,
    output logic        eng_die_sel,
    input  logic        eng_done,
    input  logic        fifo_full
);

    import qspi_read_pkg::*;

    localparam int          DIE_BIT    = $clog2(DIE_SIZE);
    localparam logic [32:0] ADDR_LIMIT = {DIE_SIZE, 1'b0};
    localparam logic [32:0] SEG_MASK   = 33'(SEG_MAX - 1);
    localparam logic [32:0] SEG_SPAN   = 33'(SEG_MAX);

    logic clk;
    logic rst;
    assign clk = CLK_25M_CKMNG_MAIN_PLD;
    assign rst = PWRGD_P1V2_MAX10_AUX_PLD_R;

    state_t      state_q, state_d;
    logic [31:0] cur_addr_q, cur_addr_d;
    logic [31:0] end_addr_q, end_addr_d;
    logic [1:0]  mode_q, mode_d;
    logic [1:0]  gnt_q, gnt_d;
    logic        die_q, die_d;
    logic [1:0]  done_q, done_d;
    logic [1:0]  err_q, err_d;
    logic        eng_start_q, eng_start_d;
    logic [31:0] eng_addr_q, eng_addr_d;
    logic [8:0]  eng_len_q, eng_len_d;
    logic        eng_die_switch_q, eng_die_switch_d;
    logic        eng_die_sel_q, eng_die_sel_d;

    logic [1:0]  arb_gnt;
    logic        arb_advance;

    logic [32:0] rem_len;
    logic [32:0] seg_room;
    logic [32:0] seg_len;
    logic [32:0] next_addr;
    logic        range_bad;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .advance (arb_advance),
        .gnt     (arb_gnt)
    );

    // Segment sizing and range validation, all at 33 bits so a full
    // 256-byte segment and addresses near 4 GiB cannot wrap.
    always_comb begin
        rem_len   = {1'b0, end_addr_q} - {1'b0, cur_addr_q} + 33'd1;
        seg_room  = SEG_SPAN - ({1'b0, cur_addr_q} & SEG_MASK);
        seg_len   = (rem_len < seg_room) ? rem_len : seg_room;
        next_addr = {1'b0, cur_addr_q} + {24'd0, eng_len_q};
        range_bad = ({1'b0, end_addr_q} < {1'b0, cur_addr_q})
                  || !mode_is_legal(mode_q)
                  || ({1'b0, end_addr_q} >= ADDR_LIMIT);
    end

    // Next-state and registered-output computation for the scheduler FSM.
    always_comb begin
        state_d          = state_q;
        cur_addr_d       = cur_addr_q;
        end_addr_d       = end_addr_q;
        mode_d           = mode_q;
        gnt_d            = gnt_q;
        die_d            = die_q;
        done_d           = 2'b00;
        err_d            = 2'b00;
        eng_start_d      = 1'b0;
        eng_addr_d       = eng_addr_q;
        eng_len_d        = eng_len_q;
        eng_die_switch_d = 1'b0;
        eng_die_sel_d    = eng_die_sel_q;
        arb_advance      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req != 2'b00) begin
                    state_d = ST_ARB;
                end
            end
            ST_ARB: begin
                if (arb_gnt != 2'b00) begin
                    arb_advance = 1'b1;
                    gnt_d       = arb_gnt;
                    if (arb_gnt[1]) begin
                        cur_addr_d = start_addr1;
                        end_addr_d = end_addr1;
                        mode_d     = mode1;
                    end else begin
                        cur_addr_d = start_addr0;
                        end_addr_d = end_addr0;
                        mode_d     = mode0;
                    end
                    state_d = ST_CHECK;
                end else begin
                    // Request withdrawn before it could be granted.
                    state_d = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (range_bad) begin
                    err_d   = gnt_q;
                    state_d = ST_FIN;
                end else if (cur_addr_q[DIE_BIT] != die_q) begin
                    state_d = ST_DIE;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_DIE: begin
                eng_die_switch_d = 1'b1;
                eng_die_sel_d    = cur_addr_q[DIE_BIT];
                state_d          = ST_DIE_WAIT;
            end
            ST_DIE_WAIT: begin
                if (eng_done) begin
                    die_d   = eng_die_sel_q;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!fifo_full) begin
                    eng_start_d = 1'b1;
                    eng_addr_d  = cur_addr_q;
                    eng_len_d   = 9'(seg_len);
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (eng_done) begin
                    cur_addr_d = 32'(next_addr);
                    if (next_addr > {1'b0, end_addr_q}) begin
                        done_d  = gnt_q;
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_FIN: begin
                gnt_d   = 2'b00;
                state_d = ST_IDLE;
            end
            default: begin
                gnt_d   = 2'b00;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any transfer silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            cur_addr_q       <= 32'd0;
            end_addr_q       <= 32'd0;
            mode_q           <= MODE_SINGLE;
            gnt_q            <= 2'b00;
            die_q            <= 1'b0;
            done_q           <= 2'b00;
            err_q            <= 2'b00;
            eng_start_q      <= 1'b0;
            eng_addr_q       <= 32'd0;
            eng_len_q        <= 9'd0;
            eng_die_switch_q <= 1'b0;
            eng_die_sel_q    <= 1'b0;
        end else begin
            state_q          <= state_d;
            cur_addr_q       <= cur_addr_d;
            end_addr_q       <= end_addr_d;
            mode_q           <= mode_d;
            gnt_q            <= gnt_d;
            die_q            <= die_d;
            done_q           <= done_d;
            err_q            <= err_d;
            eng_start_q      <= eng_start_d;
            eng_addr_q       <= eng_addr_d;
            eng_len_q        <= eng_len_d;
            eng_die_switch_q <= eng_die_switch_d;
            eng_die_sel_q    <= eng_die_sel_d;
        end
    end

    assign gnt            = gnt_q;
    assign done           = done_q;
    assign err            = err_q;
    assign busy           = (state_q != ST_IDLE);
    assign eng_start      = eng_start_q;
    assign eng_addr       = eng_addr_q;
    assign eng_len        = eng_len_q;
    assign eng_mode       = (gnt_q != 2'b00) ? mode_q : MODE_SINGLE;
    assign eng_die_switch = eng_die_switch_q;
    assign eng_die_sel    = eng_die_sel_q;

endmodule
